// File: rtl/config_reply_framer.sv
// config_reply_framer: queues readback responses and config faults in a
// small FIFO, packs each entry into a 9-bit odd-parity frame and hands it
// to the UART transmitter with a send / tx_done handshake.
module config_reply_framer #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         PTR_W      = 2,
  parameter int         TIMEOUT    = 1023,
  parameter logic [3:0] ERR_CODE   = 4'hE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_valid,
  input  logic [3:0] rsp_address,
  input  logic [3:0] rsp_data,
  input  logic       fault,
  input  logic       tx_done,
  output logic [8:0] frame_out,
  output logic       send,
  output logic       busy,
  output logic       overflow,
  output logic       timeout
);

  localparam int             CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [1:0]     S_IDLE     = 2'd0;
  localparam logic [1:0]     S_LOAD     = 2'd1;
  localparam logic [1:0]     S_WAIT     = 2'd2;
  localparam logic [3:0]     FAULT_ADDR = 4'hF;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  // FIFO storage: each entry is {address, data}; parity is added on pop
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  // transmit side
  logic [1:0]       state_q, state_d;
  logic [8:0]       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic [7:0]       push_entry;
  logic [7:0]       head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  // The head is taken whenever the transmitter is idle and has work
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign push_req   = fault | rsp_valid;
  // Fault replies replace a same-cycle response
  assign push_entry = fault ? {FAULT_ADDR, ERR_CODE} : {rsp_address, rsp_data};
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push_ok    = push_req && (!fifo_full || pop);
  assign head       = mem_q[rd_ptr_q];

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
    // Lost response behind a fault, or a push refused for lack of room
    if ((fault && rsp_valid) || (push_req && !push_ok)) begin
      overflow_d = 1'b1;
    end
  end

  // Transmit FSM: IDLE pops into the frame register, LOAD pulses send,
  // WAIT holds the frame until tx_done or the watchdog expires
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          frame_d = {~(^head), head};
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO entry registers, one per slot
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
    // Slot storage, cleared so a reset leaves no stale frames behind
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      frame_q    <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign frame_out = frame_q;
  assign send      = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_config_reply_framer.sv
// Testbench for config_reply_framer: table vectors, directed corner
// sequences and random traffic checked against a queue-based model.
module tb_config_reply_framer;

  localparam int TMO   = 1023;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rsp_valid = 1'b0;
  logic [3:0] rsp_address = 4'h0;
  logic [3:0] rsp_data = 4'h0;
  logic       fault = 1'b0;
  logic       tx_done = 1'b0;
  logic [8:0] frame_out;
  logic       send;
  logic       busy;
  logic       overflow;
  logic       timeout;

  always #5 clk = ~clk;

  config_reply_framer #(
    .FIFO_DEPTH(4),
    .PTR_W(2),
    .TIMEOUT(TMO),
    .ERR_CODE(4'hE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rsp_valid(rsp_valid),
    .rsp_address(rsp_address),
    .rsp_data(rsp_data),
    .fault(fault),
    .tx_done(tx_done),
    .frame_out(frame_out),
    .send(send),
    .busy(busy),
    .overflow(overflow),
    .timeout(timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending frames in a queue, link phase 0=free,
  // 1=frame being announced, 2=waiting for the UART
  logic [8:0] mq[$];
  int         ph;
  int         wcnt;
  logic [8:0] m_frame;
  bit         m_ovf;
  bit         m_to;

  function automatic logic [8:0] mk_frame(input logic [3:0] a, input logic [3:0] d);
    logic [7:0] b;
    b = {a, d};
    return {~(^b), b};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ph      = 0;
    wcnt    = 0;
    m_frame = 9'h000;
    m_ovf   = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame"}, frame_out, 9'h000);
    chk({tag, "_send"}, 9'(send), 9'h000);
    chk({tag, "_busy"}, 9'(busy), 9'h000);
    chk({tag, "_ovf"}, 9'(overflow), 9'h000);
    chk({tag, "_to"}, 9'(timeout), 9'h000);
  endtask

  // One clock: drive inputs, advance model, compare every output
  task automatic step(input bit rv, input logic [3:0] a, input logic [3:0] d,
                      input bit flt, input bit txd);
    bit         pop;
    logic [8:0] e;
    rsp_valid   = rv;
    rsp_address = a;
    rsp_data    = d;
    fault       = flt;
    tx_done     = txd;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    fault     = 1'b0;
    tx_done   = 1'b0;
    pop = (ph == 0) && (mq.size() > 0);
    e   = flt ? 9'h0FE : mk_frame(a, d);
    if (flt && rv) m_ovf = 1'b1;
    if (ph == 1) begin
      ph   = 2;
      wcnt = 0;
    end else if (ph == 2) begin
      if (txd) ph = 0;
      else if (wcnt == TMO) begin
        m_to = 1'b1;
        ph   = 0;
      end else wcnt++;
    end
    if (pop) begin
      m_frame = mq.pop_front();
      ph      = 1;
    end
    if (flt || rv) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1'b1;
    end
    chk("m_send", 9'(send), 9'(ph == 1));
    chk("m_busy", 9'(busy), 9'((ph != 0) || (mq.size() > 0)));
    chk("m_frame", frame_out, m_frame);
    chk("m_ovf", 9'(overflow), 9'(m_ovf));
    chk("m_to", 9'(timeout), 9'(m_to));
    if (send) $display("frame sent %h at %0t", frame_out, $time);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic done();
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Wait (bounded) for a send, check its frame, then complete the handshake
  task automatic expect_send(input string name, input logic [8:0] exp);
    int k;
    k = 0;
    while (!send && k < 20) begin
      idle();
      k++;
    end
    chk({name, "_seen"}, 9'(send), 9'h001);
    chk(name, frame_out, exp);
    idle();
    done();
  endtask

  typedef struct {
    bit         rv;
    logic [3:0] a;
    logic [3:0] d;
    bit         flt;
    bit         txd;
    bit         e_send;
    logic [8:0] e_frame;
    bit         e_busy;
    bit         e_ovf;
  } vec_t;

  vec_t vt[9];
  logic [8:0] exp_q[$];
  int k;

  initial begin
    model_reset();
    #2;
    chk_all_zero("init");

    // Single response then a fault colliding with a response
    vt[0] = '{1'b1, 4'h3, 4'hA, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0};
    vt[1] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 9'h13A, 1'b1, 1'b0};
    vt[2] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 9'h13A, 1'b1, 1'b0};
    vt[3] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 9'h13A, 1'b0, 1'b0};
    vt[4] = '{1'b1, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 9'h13A, 1'b1, 1'b1};
    vt[5] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 9'h0FE, 1'b1, 1'b1};
    vt[6] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 9'h0FE, 1'b1, 1'b1};
    vt[7] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 9'h0FE, 1'b0, 1'b1};
    vt[8] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 9'h0FE, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(vt[i].rv, vt[i].a, vt[i].d, vt[i].flt, vt[i].txd);
      chk($sformatf("tbl%0d_send", i), 9'(send), 9'(vt[i].e_send));
      chk($sformatf("tbl%0d_frame", i), frame_out, vt[i].e_frame);
      chk($sformatf("tbl%0d_busy", i), 9'(busy), 9'(vt[i].e_busy));
      chk($sformatf("tbl%0d_ovf", i), 9'(overflow), 9'(vt[i].e_ovf));
    end

    // Five responses with the UART stalled: one in flight, four queued
    do_reset();
    for (int i = 0; i < 5; i++) push(4'(i + 1), 4'(9 - i));
    chk("fill_ovf", 9'(overflow), 9'h000);
    push(4'h7, 4'h7);
    chk("sixth_ovf", 9'(overflow), 9'h001);
    chk("inflight", frame_out, mk_frame(4'h1, 4'h9));
    done();
    for (int i = 1; i < 5; i++) expect_send($sformatf("order%0d", i), mk_frame(4'(i + 1), 4'(9 - i)));
    idle();
    chk("order_busy", 9'(busy), 9'h000);

    // Watchdog: no tx_done, second entry goes out after the timeout
    do_reset();
    push(4'h2, 4'h4);
    push(4'h6, 4'h1);
    k = 0;
    while (!timeout && k < 1100) begin
      idle();
      k++;
    end
    chk_int("to_cycles", k, 1025);
    chk("to_flag", 9'(timeout), 9'h001);
    chk("to_send", 9'(send), 9'h000);
    expect_send("to_next", mk_frame(4'h6, 4'h1));

    // Full FIFO, push lands on the edge where IDLE pops
    do_reset();
    for (int i = 0; i < 5; i++) push(4'(i + 8), 4'(i));
    done();
    push(4'hC, 4'h3);
    chk("fullpop_ovf", 9'(overflow), 9'h000);
    for (int i = 1; i < 5; i++) expect_send($sformatf("fullpop%0d", i), mk_frame(4'(i + 8), 4'(i)));
    expect_send("fullpop5", mk_frame(4'hC, 4'h3));
    idle();
    chk("fullpop_busy", 9'(busy), 9'h000);
    chk("fullpop_ovf2", 9'(overflow), 9'h000);

    // Reset in WAIT with three queued entries
    do_reset();
    for (int i = 0; i < 4; i++) push(4'h1, 4'(i));
    idle();
    rst = 1'b0;
    #1;
    model_reset();
    chk_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("postrst_send", 9'(send), 9'h000);
    end
    push(4'h9, 4'h0);
    expect_send("postrst_new", mk_frame(4'h9, 4'h0));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 35), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
